// File: rtl/rename_free_list.sv
// ---------------------------------------------------------------------------
// rename_free_list
//
// Multi-port physical-register free list for the rename stage. Unallocated
// physical register indices live in a circular buffer addressed by a read
// pointer (allocation side) and a write pointer (commit/free side). Both
// pointers carry an extra wrap bit so that full and empty can be told apart.
// Allocation is all-or-nothing across the requesting lanes. Branch
// checkpoints snapshot the read pointer, so a mispredict returns every
// speculative allocation in a single cycle.
//
// Ports
//   clk_i              clock, all state updates on the rising edge
//   rst_ni             synchronous reset, active low
//   alloc_req_i        per-lane allocation request
//   alloc_grant_o      every requesting lane is granted this cycle
//   alloc_preg_o       physical register index offered to each lane
//   free_valid_i       per-lane free strobe from commit
//   free_preg_i        physical register index returned by each lane
//   ckpt_save_i        snapshot the post-allocation read pointer
//   ckpt_save_id_i     checkpoint slot to write
//   ckpt_restore_i     restore the read pointer from a checkpoint slot
//   ckpt_restore_id_i  checkpoint slot to read
//   free_count_o       number of entries currently on the list
//   empty_o            free_count_o == 0
//   overflow_err_o     sticky: a free set was dropped for lack of room
// ---------------------------------------------------------------------------
module rename_free_list #(
   parameter int unsigned NUM_PREGS   = 128,
   parameter int unsigned NUM_AREGS   = 32,
   parameter int unsigned ALLOC_PORTS = 2,
   parameter int unsigned FREE_PORTS  = 2,
   parameter int unsigned NUM_CKPT    = 4,
   localparam int unsigned PREG_W     = $clog2(NUM_PREGS),
   localparam int unsigned PTR_W      = PREG_W + 1,
   localparam int unsigned CKPT_W     = $clog2(NUM_CKPT)
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [ALLOC_PORTS-1:0]              alloc_req_i,
   output logic                                alloc_grant_o,
   output logic [ALLOC_PORTS-1:0][PREG_W-1:0]  alloc_preg_o,
   input  logic [FREE_PORTS-1:0]               free_valid_i,
   input  logic [FREE_PORTS-1:0][PREG_W-1:0]   free_preg_i,
   input  logic                                ckpt_save_i,
   input  logic [CKPT_W-1:0]                   ckpt_save_id_i,
   input  logic                                ckpt_restore_i,
   input  logic [CKPT_W-1:0]                   ckpt_restore_id_i,
   output logic [PTR_W-1:0]                    free_count_o,
   output logic                                empty_o,
   output logic                                overflow_err_o
);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [PREG_W-1:0] mem_q  [NUM_PREGS];
   logic [PTR_W-1:0]  ckpt_q [NUM_CKPT];
   logic [PTR_W-1:0]  r_ptr_q, r_ptr_d;
   logic [PTR_W-1:0]  w_ptr_q, w_ptr_d;
   logic              overflow_q, overflow_d;

   // ------------------------------------------------------------------------
   // Lane compaction: each active lane is offset by the number of active
   // lanes below it, so requests/frees pack densely into the buffer.
   // ------------------------------------------------------------------------
   logic [PTR_W-1:0]  n_req, n_free;
   logic [PTR_W-1:0]  alloc_off [ALLOC_PORTS];
   logic [PTR_W-1:0]  free_off  [FREE_PORTS];

   always_comb begin
      // NOTE: blocking assignments here are deliberate; n_req/n_free act as
      // running sums across the loop, and every output gets a value first.
      n_req  = '0;
      n_free = '0;
      for (int k = 0; k < int'(ALLOC_PORTS); k++) begin
         alloc_off[k] = n_req;
         n_req        = n_req + PTR_W'(alloc_req_i[k]);
      end
      for (int j = 0; j < int'(FREE_PORTS); j++) begin
         free_off[j] = n_free;
         n_free      = n_free + PTR_W'(free_valid_i[j]);
      end
   end

   // ------------------------------------------------------------------------
   // Allocation side
   // ------------------------------------------------------------------------
   logic [PTR_W-1:0] rd_ptr [ALLOC_PORTS];
   logic [PTR_W-1:0] r_ptr_alloc;

   assign free_count_o   = w_ptr_q - r_ptr_q;
   assign empty_o        = (free_count_o == '0);
   assign overflow_err_o = overflow_q;

   // A restore steals the read pointer this cycle, so allocation must wait.
   assign alloc_grant_o = (n_req != '0) && (free_count_o >= n_req) && !ckpt_restore_i;

   always_comb begin
      for (int k = 0; k < int'(ALLOC_PORTS); k++) begin
         rd_ptr[k]       = r_ptr_q + alloc_off[k];
         alloc_preg_o[k] = mem_q[rd_ptr[k][PREG_W-1:0]];
      end
   end

   // Read pointer as it stands after this cycle's allocation; this is also
   // what a checkpoint captures, so the branch keeps its own rename.
   assign r_ptr_alloc = alloc_grant_o ? (r_ptr_q + n_req) : r_ptr_q;
   assign r_ptr_d     = ckpt_restore_i ? ckpt_q[ckpt_restore_id_i] : r_ptr_alloc;

   // ------------------------------------------------------------------------
   // Free side. Room is judged against the registered count only, so a
   // same-cycle allocation never makes space for a same-cycle free.
   // ------------------------------------------------------------------------
   logic [PTR_W:0]    fill_after;
   logic              free_accept;
   logic [PREG_W-1:0] free_idx [FREE_PORTS];

   assign fill_after  = {1'b0, free_count_o} + {1'b0, n_free};
   assign free_accept = (fill_after <= (PTR_W+1)'(NUM_PREGS));
   assign w_ptr_d     = free_accept ? (w_ptr_q + n_free) : w_ptr_q;
   assign overflow_d  = overflow_q | ~free_accept;

   always_comb begin
      for (int j = 0; j < int'(FREE_PORTS); j++) begin
         free_idx[j] = PREG_W'(w_ptr_q + free_off[j]);
      end
   end

   // ------------------------------------------------------------------------
   // Pointer, flag and checkpoint registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values regardless of statement order.
      if (!rst_ni) begin
         r_ptr_q    <= '0;
         w_ptr_q    <= PTR_W'(NUM_PREGS - NUM_AREGS);
         overflow_q <= 1'b0;
         for (int c = 0; c < int'(NUM_CKPT); c++) begin
            ckpt_q[c] <= '0;
         end
      end else begin
         r_ptr_q    <= r_ptr_d;
         w_ptr_q    <= w_ptr_d;
         overflow_q <= overflow_d;
         if (ckpt_save_i && !ckpt_restore_i) begin
            ckpt_q[ckpt_save_id_i] <= r_ptr_alloc;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Free-list storage
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      // NOTE: this array is reset on purpose; its reset contents are the
      // initial free set (every register above the architectural ones).
      if (!rst_ni) begin
         for (int i = 0; i < int'(NUM_PREGS); i++) begin
            mem_q[i] <= (i < int'(NUM_PREGS - NUM_AREGS)) ? PREG_W'(int'(NUM_AREGS) + i) : '0;
         end
      end else if (free_accept) begin
         for (int j = 0; j < int'(FREE_PORTS); j++) begin
            if (free_valid_i[j]) begin
               mem_q[free_idx[j]] <= free_preg_i[j];
            end
         end
      end
   end

endmodule

// File: tb/tb_rename_free_list.sv
// ---------------------------------------------------------------------------
// tb_rename_free_list
//
// Directed bench for rename_free_list with default parameters. The stimulus
// process drives one cycle at a time and pushes that cycle's expected outputs
// into a scoreboard queue; a separate monitor pops one entry per cycle on the
// falling edge and compares. A field of -1 means "not checked this cycle".
// ---------------------------------------------------------------------------
module tb_rename_free_list;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [1:0]            alloc_req;
   logic                  alloc_grant;
   logic [1:0][6:0]       alloc_preg;
   logic [1:0]            free_valid;
   logic [1:0][6:0]       free_preg;
   logic                  ckpt_save;
   logic [1:0]            ckpt_save_id;
   logic                  ckpt_restore;
   logic [1:0]            ckpt_restore_id;
   logic [7:0]            free_count;
   logic                  empty;
   logic                  overflow_err;

   always #5 clk = ~clk;

   rename_free_list dut (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .alloc_req_i       (alloc_req),
      .alloc_grant_o     (alloc_grant),
      .alloc_preg_o      (alloc_preg),
      .free_valid_i      (free_valid),
      .free_preg_i       (free_preg),
      .ckpt_save_i       (ckpt_save),
      .ckpt_save_id_i    (ckpt_save_id),
      .ckpt_restore_i    (ckpt_restore),
      .ckpt_restore_id_i (ckpt_restore_id),
      .free_count_o      (free_count),
      .empty_o           (empty),
      .overflow_err_o    (overflow_err)
   );

   typedef struct {
      string name;
      int    g;
      int    p0;
      int    p1;
      int    fc;
      int    emp;
      int    ovf;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", n, act, exp);
      end
   endtask

   function automatic exp_t ex(input string n, input int g, input int p0, input int p1,
                               input int fc, input int emp = -1, input int ovf = -1);
      exp_t e;
      e.name = n; e.g = g; e.p0 = p0; e.p1 = p1; e.fc = fc; e.emp = emp; e.ovf = ovf;
      return e;
   endfunction

   // ------------------------------------------------------------------------
   // Monitor: one scoreboard entry per driven cycle, compared mid-cycle.
   // ------------------------------------------------------------------------
   always @(negedge clk) begin
      if (sb_q.size() != 0) begin
         mon_e = sb_q.pop_front();
         if (mon_e.g   >= 0) check({mon_e.name, ".grant"},      int'(alloc_grant),   mon_e.g);
         if (mon_e.p0  >= 0) check({mon_e.name, ".preg0"},      int'(alloc_preg[0]), mon_e.p0);
         if (mon_e.p1  >= 0) check({mon_e.name, ".preg1"},      int'(alloc_preg[1]), mon_e.p1);
         if (mon_e.fc  >= 0) check({mon_e.name, ".free_count"}, int'(free_count),    mon_e.fc);
         if (mon_e.emp >= 0) check({mon_e.name, ".empty"},      int'(empty),         mon_e.emp);
         if (mon_e.ovf >= 0) check({mon_e.name, ".overflow"},   int'(overflow_err),  mon_e.ovf);
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   task automatic step(input logic [1:0] req, input logic [1:0] fv, input int f0, input int f1,
                       input logic save, input int sid, input logic rest, input int rid,
                       input exp_t e);
      @(posedge clk);
      #1;
      alloc_req       = req;
      free_valid      = fv;
      free_preg[0]    = 7'(f0);
      free_preg[1]    = 7'(f1);
      ckpt_save       = save;
      ckpt_save_id    = 2'(sid);
      ckpt_restore    = rest;
      ckpt_restore_id = 2'(rid);
      sb_q.push_back(e);
   endtask

   task automatic alloc(input logic [1:0] req, input exp_t e);
      step(req, 2'b00, 0, 0, 1'b0, 0, 1'b0, 0, e);
   endtask

   task automatic free2(input logic [1:0] fv, input int f0, input int f1, input exp_t e);
      step(2'b00, fv, f0, f1, 1'b0, 0, 1'b0, 0, e);
   endtask

   task automatic idle_inputs();
      alloc_req = '0; free_valid = '0; free_preg = '0;
      ckpt_save = 1'b0; ckpt_save_id = '0; ckpt_restore = 1'b0; ckpt_restore_id = '0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      idle_inputs();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // ------------------------------------------------------------------------
   // Directed sequence
   // ------------------------------------------------------------------------
   initial begin
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reset state: list holds p32..p127.
      alloc(2'b00, ex("reset", 0, 32, -1, 96, 0, 0));

      // Dual allocation, then a lane-1-only request packs to offset 0.
      for (int k = 0; k < 3; k++)
         alloc(2'b11, ex($sformatf("dual%0d", k), 1, 32 + 2*k, 33 + 2*k, 96 - 2*k));
      alloc(2'b10, ex("lane1_only", 1, -1, 38, 90));

      // Drain down to a single free entry.
      for (int k = 0; k < 44; k++)
         alloc(2'b11, ex($sformatf("drain%0d", k), 1, 39 + 2*k, 40 + 2*k, 89 - 2*k));
      alloc(2'b11, ex("exhaust_pair_denied", 0, -1, -1, 1, 0));
      alloc(2'b00, ex("exhaust_hold", 0, -1, -1, 1, 0));
      alloc(2'b01, ex("exhaust_last", 1, 127, -1, 1, 0));
      alloc(2'b00, ex("empty_now", 0, -1, -1, 0, 1));
      alloc(2'b11, ex("empty_denied", 0, -1, -1, 0, 1));

      // Free two at once; not visible until the next cycle.
      free2(2'b11, 5, 9, ex("free_same_cycle", 0, -1, -1, 0, 1));
      alloc(2'b11, ex("reuse", 1, 5, 9, 2, 0));
      alloc(2'b00, ex("reuse_empty", 0, -1, -1, 0, 1));

      // Refill up to the array end, then a pair that straddles index 127 -> 0.
      for (int k = 0; k < 14; k++)
         free2(2'b11, 40 + 2*k, 41 + 2*k, ex($sformatf("refill%0d", k), -1, -1, -1, 2*k));
      free2(2'b10, 0, 70, ex("free_lane1_only", -1, -1, -1, 28));
      free2(2'b11, 80, 81, ex("free_wrap_pair", -1, -1, -1, 29));
      for (int k = 0; k < 14; k++)
         alloc(2'b11, ex($sformatf("realloc%0d", k), 1, 40 + 2*k, 41 + 2*k, 31 - 2*k));
      alloc(2'b01, ex("realloc_single", 1, 70, -1, 3));
      alloc(2'b11, ex("alloc_wrap_pair", 1, 80, 81, 2));
      alloc(2'b00, ex("wrap_empty", 0, -1, -1, 0, 1));

      // Checkpoint save / restore.
      do_reset();
      step(2'b11, 2'b00, 0, 0, 1'b1, 2, 1'b0, 0, ex("ckpt_save", 1, 32, 33, 96));
      alloc(2'b11, ex("ckpt_spec0", 1, 34, 35, 94));
      alloc(2'b11, ex("ckpt_spec1", 1, 36, 37, 92));
      step(2'b11, 2'b01, 36, 0, 1'b1, 2, 1'b1, 2, ex("ckpt_restore", 0, -1, -1, 90));
      alloc(2'b01, ex("after_restore", 1, 34, -1, 95));
      step(2'b00, 2'b00, 0, 0, 1'b0, 0, 1'b1, 2, ex("restore_again", 0, -1, -1, 94));
      alloc(2'b00, ex("save_ignored", 0, 34, -1, 95));
      step(2'b00, 2'b00, 0, 0, 1'b1, 1, 1'b0, 0, ex("save_no_alloc", 0, 34, -1, 95));
      alloc(2'b11, ex("after_save1", 1, 34, 35, 95));
      step(2'b00, 2'b00, 0, 0, 1'b0, 0, 1'b1, 1, ex("restore_slot1", 0, -1, -1, 93));
      alloc(2'b00, ex("slot1_value", 0, 34, -1, 95));

      // A two-lane free that would exceed capacity by one is dropped whole.
      do_reset();
      for (int i = 0; i < 31; i++)
         free2(2'b01, i, 0, ex($sformatf("fill%0d", i), -1, -1, -1, 96 + i, -1, 0));
      free2(2'b11, 40, 41, ex("pair_overflow", -1, -1, -1, 127, -1, 0));
      alloc(2'b00, ex("pair_dropped", -1, -1, -1, 127, 0, 1));

      // Single-lane frees: the 33rd overflows, flag is sticky until reset.
      do_reset();
      for (int i = 0; i < 33; i++)
         free2(2'b01, i, 0,
               ex($sformatf("ovf_free%0d", i), -1, -1, -1, (96 + i > 128) ? 128 : 96 + i, -1, 0));
      alloc(2'b00, ex("ovf_set", -1, -1, -1, 128, 0, 1));
      alloc(2'b11, ex("ovf_alloc", 1, 32, 33, 128, 0, 1));
      alloc(2'b00, ex("ovf_sticky", -1, -1, -1, 126, 0, 1));
      do_reset();
      alloc(2'b00, ex("ovf_cleared", 0, 32, -1, 96, 0, 0));

      // Let the monitor consume the remaining entries, bounded.
      for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
      #1;
      check("scoreboard_drained", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
